// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file write arbiter.
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths of the register file
//   NUM_REGS                : number of architectural registers (32)
//   ZERO_REG                : hard-wired zero register, never written
//   arb_state_t             : arbiter state encoding (INIT=0, RUN=1)
//   rr_next()               : round-robin successor of a requester index
package regfile_arb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 0;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_t;

   // Index that follows idx in a ring of n requesters.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return ((idx + 1) >= n) ? 0 : (idx + 1);
   endfunction

endpackage

// File: rtl/regfile_rr_picker.sv
// Combinational round-robin picker.
//
// Searches ReqValid starting at index `pointer` and moving upward, wrapping
// modulo NUM_REQ, and selects the first valid requester.
//
// Ports:
//   ReqValid  [NUM_REQ-1:0] in  : per-requester valid
//   pointer   [PTR_W-1:0]   in  : search start index (always < NUM_REQ)
//   grant     [NUM_REQ-1:0] out : one-hot grant, all-zero when nothing valid
//   grant_idx [PTR_W-1:0]   out : index of the granted requester (0 when idle)
//   any_valid               out : at least one requester valid
module regfile_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] ReqValid,
   input  logic [PTR_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               any_valid
);

   always_comb begin
      int                idx;
      logic [PTR_W-1:0]  sel;
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(pointer) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         sel = PTR_W'(idx);
         if (!any_valid && ReqValid[sel]) begin
            any_valid  = 1'b1;
            grant[sel] = 1'b1;
            grant_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ
// writeback requesters with a valid/ready handshake. The write port signals
// (WriteRegister/WriteData/RegWrite) come straight from flops, so an accepted
// request reaches the register file on the edge after the handshake.
//
// Build option: define REGFILE_ARB_INIT_EN to add a post-reset sweep that
// writes zero into registers 1..31 (one per cycle) before traffic is accepted.
// Without it the arbiter comes out of reset directly in RUN.
//
// Ports:
//   Clk            in  : clock, rising edge
//   Reset_n        in  : asynchronous active-low reset
//   ReqValid       in  [NUM_REQ]        : request valid per requester
//   ReqReady       out [NUM_REQ]        : one-hot accept (combinational)
//   ReqAddr        in  [NUM_REQ*ADDR_W] : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   ReqData        in  [NUM_REQ*DATA_W] : packed data, requester i at [i*DATA_W +: DATA_W]
//   WriteRegister  out [ADDR_W]         : register file write address
//   WriteData      out [DATA_W]         : register file write data
//   RegWrite       out                  : register file write enable
//   InitDone       out                  : arbiter is in RUN
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | zero sweep of registers 1..31, no requester is accepted
// ST_RUN  | round-robin arbitration of writeback requests
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic [NUM_REQ-1:0]        ReqValid,
   output logic [NUM_REQ-1:0]        ReqReady,
   input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
   input  logic [NUM_REQ*DATA_W-1:0] ReqData,
   output logic [ADDR_W-1:0]         WriteRegister,
   output logic [DATA_W-1:0]         WriteData,
   output logic                      RegWrite,
   output logic                      InitDone
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               any_valid;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]  wreg_q, wreg_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               wen_q, wen_d;
   logic               run_live;
   arb_state_t         state_q;

   logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
   logic [DATA_W-1:0]  data_arr [NUM_REQ];
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i] = ReqAddr[i*ADDR_W +: ADDR_W];
      assign data_arr[i] = ReqData[i*DATA_W +: DATA_W];
   end

   assign sel_addr = addr_arr[grant_idx];
   assign sel_data = data_arr[grant_idx];

   regfile_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .ReqValid  (ReqValid),
      .pointer   (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_valid (any_valid)
   );

`ifdef REGFILE_ARB_INIT_EN
   localparam logic [ADDR_W-1:0] SWEEP_FIRST = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] SWEEP_LAST  = ADDR_W'(NUM_REGS - 1);

   arb_state_t        state_d;
   logic [ADDR_W-1:0] sweep_q, sweep_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if ((state_q == ST_INIT) && (sweep_q == SWEEP_LAST)) begin
         state_d = ST_RUN;
      end
   end
`else
   assign state_q = ST_RUN;
`endif

   // Reset_n is folded in so that ReqReady/InitDone drop the instant reset
   // asserts and come back the instant it releases, without waiting for Clk.
   assign run_live = (state_q == ST_RUN) && Reset_n;

   always_comb begin
      ReqReady = '0;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;
      wen_d    = 1'b0;
      ptr_d    = ptr_q;
`ifdef REGFILE_ARB_INIT_EN
      sweep_d  = sweep_q;
      if (state_q == ST_INIT) begin
         wreg_d  = sweep_q;
         wdata_d = '0;
         wen_d   = 1'b1;
         if (sweep_q != SWEEP_LAST) begin
            sweep_d = sweep_q + 1'b1;
         end
      end
`endif
      if (run_live && any_valid) begin
         ReqReady = grant;
         ptr_d    = PTR_W'(rr_next(32'(grant_idx), NUM_REQ));
         // A write to the zero register is accepted but dropped; the port
         // keeps its last address/data so only RegWrite changes.
         if (sel_addr != ADDR_W'(ZERO_REG)) begin
            wreg_d  = sel_addr;
            wdata_d = sel_data;
            wen_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr_q   <= '0;
         wreg_q  <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
      end
   end

`ifdef REGFILE_ARB_INIT_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sweep_q <= SWEEP_FIRST;
      end else begin
         sweep_q <= sweep_d;
      end
   end
`endif

   assign WriteRegister = wreg_q;
   assign WriteData     = wdata_q;
   assign RegWrite      = wen_q;
   assign InitDone      = run_live;

endmodule
